dispatch_queue: RTL and testbench

- N-wide circular instruction buffer between fetch/decode and the out-of-order core. It is the producer side of the core's dispatch interface.
- Enqueues up to N decoded instructions per cycle.
- Presents up to N oldest instructions in program order for dispatch.
- Holds them while the core asserts structural_hazard; discards everything on squash.
- A combinational packer in the ID stage maps its output lanes into ID_OOO_PACKET (rat/rob/rs fields).

---
 rtl/dispatch_queue_pkg.sv | 51 +++++
 rtl/dispatch_queue_compact.sv | 27 ++
 rtl/dispatch_queue.sv | 112 +++++++++++
 tb/tb_dispatch_queue.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared types for the ID-stage dispatch queue: decoded-instruction payload
// (ID_DQ_ENTRY), functional-unit / operand-select encodings and default sizing.
// Latency: n/a (types only). Backpressure: n/a.
package dispatch_queue_pkg;

  localparam int unsigned DQ_WIDTH = 2;  // default lanes per cycle
  localparam int unsigned DQ_DEPTH = 8;  // default queue entries

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULT   = 3'd1,
    FU_LOAD   = 3'd2,
    FU_STORE  = 3'd3,
    FU_BRANCH = 3'd4,
    FU_NONE   = 3'd7
  } fu_t;

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'd0,
    OPA_IS_NPC  = 2'd1,
    OPA_IS_PC   = 2'd2,
    OPA_IS_ZERO = 2'd3
  } opa_sel_t;

  typedef enum logic [1:0] {
    OPB_IS_RS2   = 2'd0,
    OPB_IS_I_IMM = 2'd1,
    OPB_IS_S_IMM = 2'd2,
    OPB_IS_B_IMM = 2'd3
  } opb_sel_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    fu_t         fu;
    logic [4:0]  func;
    opa_sel_t    opa_select;
    opb_sel_t    opb_select;
    logic        cond_branch;
    logic        uncond_branch;
    logic [4:0]  dest_arn;
    logic [4:0]  op1_arn;
    logic [4:0]  op2_arn;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        illegal;
    logic        halt;
  } ID_DQ_ENTRY;

endpackage

// File: rtl/dispatch_queue_compact.sv
// N-lane compactor: turns a sparse valid mask into dense write offsets
// (offset[i] = number of valid lanes below lane i) plus the total popcount.
// Latency: purely combinational. Backpressure: none; the caller gates the write.
// Ports: in_valid_i (N lane mask) -> offset_o (per-lane slot offset), popcount_o.
module dispatch_queue_compact #(
  parameter int unsigned N   = 2,
  parameter int unsigned NCW = $clog2(N + 1)
) (
  input  logic [N-1:0]          in_valid_i,
  output logic [N-1:0][NCW-1:0] offset_o,
  output logic [NCW-1:0]        popcount_o
);

  logic [NCW-1:0] acc;

  // Running prefix count: each lane's offset is the number of older valid lanes.
  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      offset_o[i] = acc;
      acc         = acc + NCW'(in_valid_i[i]);
    end
    popcount_o = acc;
  end

endmodule

// File: rtl/dispatch_queue.sv
// Circular N-wide instruction buffer between decode and the out-of-order core.
// Latency: entry written at edge t is visible on out_* after edge t (no bypass).
// Backpressure: in_ready drops when fewer than N slots are free; requests
// presented while in_ready=0 are dropped and must be held upstream.
// Ports: clock/reset (async active-high); squash, structural_hazard from core;
// in_valid/in_entries/in_ready enqueue side; out_valid/out_entries/count dispatch side.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned N     = DQ_WIDTH,
  parameter int unsigned DEPTH = DQ_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic                          structural_hazard,
  input  logic [N-1:0]                  in_valid,
  input  ID_DQ_ENTRY [N-1:0]            in_entries,
  output logic                          in_ready,
  output logic [N-1:0]                  out_valid,
  output ID_DQ_ENTRY [N-1:0]            out_entries,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned NCW = $clog2(N + 1);

  // Ready means at least N free slots; equivalent to count <= DEPTH-N.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - N);
  localparam logic [CW-1:0] N_CNT     = CW'(N);

  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  ID_DQ_ENTRY     entry_q [DEPTH];

  logic [N-1:0][NCW-1:0] wr_off;
  logic [NCW-1:0]        enq_num;
  logic [CW-1:0]         deq_num;
  logic                  enq_fire;
  logic                  deq_fire;

  dispatch_queue_compact #(.N(N), .NCW(NCW)) u_compact (
    .in_valid_i (in_valid),
    .offset_o   (wr_off),
    .popcount_o (enq_num)
  );

  // Ready looks only at the registered count, never at hazard/squash.
  assign in_ready = (count_q <= READY_MAX);
  assign enq_fire = in_ready && !squash;
  assign deq_fire = !structural_hazard && !squash;
  assign deq_num  = (count_q >= N_CNT) ? N_CNT : count_q;
  assign count    = count_q;

  always_comb begin
    out_valid   = '0;
    out_entries = '0;
    for (int i = 0; i < int'(N); i++) begin
      out_valid[i]   = (count_q > CW'(i)) && !squash;
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      out_entries[i] = entry_q[head_q + PW'(i)];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PW'(enq_num);
      if (deq_fire) head_d = head_q + PW'(deq_num);
      count_d = count_q
              + (enq_fire ? CW'(enq_num) : '0)
              - (deq_fire ? deq_num : '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < int'(N); i++) begin
        if (in_valid[i]) entry_q[tail_q + PW'(wr_off[i])] <= in_entries[i];
      end
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count_q <= CW'(DEPTH));
  a_out_contig: assert property (@(posedge clock) disable iff (reset)
    ((out_valid & (out_valid + N'(1))) == '0));
  a_ptr_count: assert property (@(posedge clock) disable iff (reset)
    (PW'(tail_q - head_q) == count_q[PW-1:0]));

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue (N=2, DEPTH=8): directed scenarios
// followed by randomized traffic, all compared against a queue-based model.
// Latency/backpressure: checked through the model's per-cycle expectations.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 8;

  logic               clock;
  logic               reset;
  logic               squash;
  logic               structural_hazard;
  logic [N-1:0]       in_valid;
  ID_DQ_ENTRY [N-1:0] in_entries;
  logic               in_ready;
  logic [N-1:0]       out_valid;
  ID_DQ_ENTRY [N-1:0] out_entries;
  logic [3:0]         count;

  int n_cmp;
  int n_bad;
  int seq_id;

  ID_DQ_ENTRY mq[$];   // reference: program-ordered contents of the queue

  dispatch_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .squash            (squash),
    .structural_hazard (structural_hazard),
    .in_valid          (in_valid),
    .in_entries        (in_entries),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_entries       (out_entries),
    .count             (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic ID_DQ_ENTRY mk_entry();
    logic [$bits(ID_DQ_ENTRY)-1:0] r;
    ID_DQ_ENTRY e;
    for (int b = 0; b < $bits(ID_DQ_ENTRY); b++) r[b] = 1'($urandom_range(1, 0));
    e      = ID_DQ_ENTRY'(r);
    seq_id = seq_id + 1;
    e.inst = 32'(seq_id);
    return e;
  endfunction

  // One clock cycle: drive at edge+1, check outputs mid-cycle against the
  // model, then apply the edge to the model.
  task automatic cycle(input logic sq, input logic sh, input logic [N-1:0] iv);
    int   sz;
    logic rdy;
    int   d;
    squash            = sq;
    structural_hazard = sh;
    in_valid          = iv;
    in_entries[0]     = mk_entry();
    in_entries[1]     = mk_entry();
    sz  = mq.size();
    rdy = ((DEPTH - sz) >= N);
    #4;
    chk("count", 256'(count), 256'(sz));
    chk("in_ready", 256'(in_ready), 256'(rdy));
    for (int i = 0; i < int'(N); i++) begin
      logic ev;
      ev = (i < sz) && !sq;
      chk($sformatf("out_valid[%0d]", i), 256'(out_valid[i]), 256'(ev));
      if (ev) chk($sformatf("out_entry[%0d]", i), 256'(out_entries[i]), 256'(mq[i]));
    end
    @(posedge clock);
    if (sq) begin
      mq.delete();
    end else begin
      d = (sz < int'(N)) ? sz : int'(N);
      if (!sh) for (int k = 0; k < d; k++) void'(mq.pop_front());
      if (rdy) for (int i = 0; i < int'(N); i++) if (iv[i]) mq.push_back(in_entries[i]);
    end
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; seq_id = 0;
    reset = 1'b1; squash = 1'b0; structural_hazard = 1'b0;
    in_valid = '0; in_entries = '0;
    #2;
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    #10 reset = 1'b0;
    @(posedge clock); #1;

    // A,B enqueued together, seen next cycle, dispatched, then empty.
    cycle(0, 0, 2'b11);
    cycle(0, 0, 2'b00);
    cycle(0, 0, 2'b00);

    // Sparse lane: only lane 1 valid, lands in lane 0 of output.
    cycle(0, 0, 2'b10);
    cycle(0, 0, 2'b00);
    cycle(0, 0, 2'b00);

    // Fill under hazard; fifth attempt dropped while full; then drain.
    repeat (5) cycle(0, 1, 2'b11);
    repeat (5) cycle(0, 0, 2'b00);

    // Walk head to slot 7 with one entry, then enqueue across the wrap.
    cycle(0, 1, 2'b11);
    cycle(0, 1, 2'b11);
    cycle(0, 1, 2'b01);
    cycle(0, 0, 2'b00);
    cycle(0, 0, 2'b00);
    cycle(0, 1, 2'b11);
    repeat (3) cycle(0, 0, 2'b00);

    // Squash at count=5 with a concurrent enqueue and no hazard.
    cycle(0, 1, 2'b11);
    cycle(0, 1, 2'b11);
    cycle(0, 1, 2'b01);
    cycle(1, 0, 2'b11);
    cycle(0, 1, 2'b00);

    // Asynchronous reset between edges while holding four entries.
    cycle(0, 1, 2'b11);
    cycle(0, 1, 2'b11);
    chk("pre_arst_count", 256'(count), 256'(4));
    squash = 1'b0; structural_hazard = 1'b1; in_valid = '0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 256'(count), 256'(0));
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    #1 reset = 1'b0;
    mq.delete();
    @(posedge clock); #1;

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      logic sq, sh;
      sq = ($urandom_range(15, 0) == 0);
      sh = ($urandom_range(2, 0) == 0);
      cycle(sq, sh, 2'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
